// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake into the UART transmit FIFO.
// Latency: none (wires only); a byte transfers on an edge with tx_valid && tx_ready.
// Backpressure: tx_ready low means the queue is full and the producer holds tx_data/tx_valid.
// Signals: tx_data (byte), tx_valid (producer offers a byte), tx_ready (FIFO can take it).
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of a START/DATA/PARITY/STOP serializer.
// Latency: the start bit begins two cycles after the write edge; frames follow back-to-back.
// Backpressure: tx_ready is registered and drops when fifo_level reaches FIFO_DEPTH.
// Ports: clk, rst (sync, active-high); tx_if (slave handshake); fifo_level (queued bytes,
//        excluding the frame on the line); busy (frame on the line); serial_tx (idle high).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 100000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 tx_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          serial_tx
);
    localparam int          BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          LW        = AW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q;
    logic          wr_en;
    logic          pop;
    logic [7:0]    head;
    logic          head_par;

    // Serializer
    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          baud_last;

    assign wr_en     = tx_if.tx_valid && ready_q;
    assign head      = mem_q[rd_ptr_q] & DATA_MASK;
    // Odd parity sets the bit when the data already holds an even number of ones.
    assign head_par  = (PARITY == 1) ? ~(^head) : (^head);
    assign baud_last = (baud_q == BAUD_LAST);

    // ---------------- FIFO next-state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= tx_if.tx_data;
        end
    end

    // ---------------- Serializer next-state ----------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = 16'd0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = 3'd0;
                        // Chain straight into the next frame so there is no idle gap.
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            par_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= (level_d != LW'(FIFO_DEPTH));
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
        end
    end

    // ---------------- Outputs ----------------
    always_comb begin
        serial_tx = 1'b1;
        busy      = 1'b1;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_START:  serial_tx = 1'b0;
            S_DATA:   serial_tx = shift_q[0];
            S_PARITY: serial_tx = par_q;
            S_STOP:   serial_tx = 1'b1;
            default: begin
                serial_tx = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    assign tx_if.tx_ready = ready_q;
    assign fifo_level     = level_q;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 100000, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer division), legal range 2..65535.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two, legal 2..256.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 tx_data  input  8  byte to queue; bits above DATA_BITS-1 are ignored.
REQ-010 tx_valid  input  1  producer offers tx_data this cycle.
REQ-011 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the frame on the line.
REQ-013 busy  output  1  high while a frame is on the line (states START..STOP).
REQ-014 serial_tx  output  1  UART line, idle high.

Function
REQ-015 A write SHALL occur when tx_valid and tx_ready are both high on a clock edge; tx_valid without tx_ready SHALL be ignored, with no data loss or corruption.
REQ-016 tx_ready SHALL equal (fifo_level != FIFO_DEPTH), registered, so it is valid in the cycle after any level change.
REQ-017 FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-018 A write and a pop in the same cycle SHALL leave fifo_level unchanged and keep data order.
REQ-019 Serializer states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: serial_tx = 1 and busy = 0; if fifo_level != 0, pop the head into the shift register and go to START.
REQ-021 START SHALL drive 0 for exactly BAUD_DIV cycles, beginning the cycle after the pop.
REQ-022 DATA SHALL drive bits 0..DATA_BITS-1, LSB first, each for exactly BAUD_DIV cycles.
REQ-023 PARITY (entered only if PARITY != 0) SHALL drive the parity bit for BAUD_DIV cycles.
REQ-024 Odd parity SHALL make the count of ones over the data bits plus the parity bit odd; even parity SHALL make it even.
REQ-025 STOP SHALL drive 1 for STOP_BITS*BAUD_DIV cycles.
REQ-026 Frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles exactly.
REQ-027 On the last STOP cycle, if the FIFO is non-empty, the serializer SHALL pop and enter START directly, giving back-to-back frames with zero idle cycles; otherwise it SHALL return to IDLE.
REQ-028 The baud counter SHALL be 16 bits, count 0..BAUD_DIV-1, and clear on every bit boundary.
REQ-029 tx_data/tx_valid changes SHALL NOT affect a frame in progress.
REQ-030 An illegal state encoding SHALL return to IDLE with serial_tx = 1.

Reset
REQ-031 While rst is high: serial_tx = 1, busy = 0, fifo_level = 0, tx_ready = 1, state = IDLE, pointers and counters = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame, discard queued bytes, and drive serial_tx = 1 on the next edge.
REQ-033 Writes presented during rst SHALL be discarded.

Verification (CLK_FREQ=1_000_000, BAUD=250_000, so BAUD_DIV=4, unless stated)
REQ-034 8N1: write 0xA5 at cycle 0 -> from cycle 2, serial_tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles.
REQ-035 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2): write 0x83 -> data bits 1,1,0,0,0,0,0, parity 0, two stop bits; frame = 44 cycles.
REQ-036 8O1: write 0x00 -> parity bit = 1; write 0xFF -> parity bit = 1.
REQ-037 FIFO_DEPTH=4: burst 6 writes with tx_valid held high -> tx_ready drops once fifo_level = 4, no byte lost or duplicated, all 6 frames sent in order back-to-back with no idle gap.
REQ-038 Assert rst at cycle 15 of an 8N1 frame with 3 bytes queued -> serial_tx = 1, fifo_level = 0, busy = 0 the next cycle, and no further frames.
REQ-039 Write and pop in the same cycle at fifo_level = 2 -> fifo_level stays 2 and output order is preserved.
